uart_rx_oversample: RTL and testbench

UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

---
 rtl/uart_rx_oversample.sv | 141 ++++++++++++++
 tb/tb_uart_rx_oversample.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// UART receiver driven by a 16x oversampling tick; 2-of-3 majority vote around mid-bit,
// LSB-first data, sticky framing-error flag and single-cycle word-valid pulse.
module uart_rx_oversample #(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_status,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [3:0] CNT_MID  = 4'(OVS / 2);
    localparam logic [3:0] CNT_LAST = 4'(OVS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    logic                 rx_meta_reg, rx_s_reg;
    state_t               state_reg, state_next;
    logic [3:0]           cnt_reg, cnt_next;
    logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] data_sr_reg, data_sr_next;
    logic                 s_early_reg, s_early_next;
    logic                 s_mid_reg, s_mid_next;
    logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
    logic                 rx_status_reg, rx_status_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 maj;
    logic                 at_decide;

    // The third vote is the live synchronized sample on the decision tick.
    assign maj = (s_early_reg & s_mid_reg) | (s_early_reg & rx_s_reg) | (s_mid_reg & rx_s_reg);
    assign at_decide = sample_en && (cnt_reg == CNT_MID + 4'd1);

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            rx_meta_reg   <= 1'b1;
            rx_s_reg      <= 1'b1;
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            data_sr_reg   <= '0;
            s_early_reg   <= 1'b1;
            s_mid_reg     <= 1'b1;
            rx_data_reg   <= '0;
            rx_status_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_meta_reg   <= rx;
            rx_s_reg      <= rx_meta_reg;
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            data_sr_reg   <= data_sr_next;
            s_early_reg   <= s_early_next;
            s_mid_reg     <= s_mid_next;
            rx_data_reg   <= rx_data_next;
            rx_status_reg <= rx_status_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Each shift-register position only loads on its own data bit's decision tick.
    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_sr
            assign data_sr_next[gi] = (state_reg == DATA && at_decide && bit_idx_reg == IDX_W'(gi))
                                      ? maj : data_sr_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
        s_early_next   = s_early_reg;
        s_mid_next     = s_mid_reg;
        rx_data_next   = rx_data_reg;
        rx_status_next = 1'b0;
        frame_err_next = frame_err_reg;

        if (sample_en) begin
            if (cnt_reg == CNT_MID - 4'd1) s_early_next = rx_s_reg;
            if (cnt_reg == CNT_MID)        s_mid_next   = rx_s_reg;

            case (state_reg)
                IDLE: begin
                    if (!rx_s_reg) begin
                        state_next = START;
                        cnt_next   = '0;
                    end
                end
                START: begin
                    cnt_next = cnt_reg + 4'd1;
                    if (at_decide && maj) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
                end
                DATA: begin
                    cnt_next = cnt_reg + 4'd1;
                    if (cnt_reg == CNT_LAST) begin
                        if (bit_idx_reg == IDX_W'(DATA_BITS - 1)) state_next = STOP;
                        else bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
                STOP: begin
                    cnt_next = cnt_reg + 4'd1;
                    if (at_decide) begin
                        // Returning half a bit early leaves room to catch the next start edge.
                        cnt_next       = '0;
                        rx_data_next   = data_sr_reg;
                        rx_status_next = maj;
                        frame_err_next = !maj;
                        state_next     = maj ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s_reg) state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_status = rx_status_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench: frames are built bit-by-bit from the UART frame definition and the
// received word, error flag, pulse count and busy are compared against that frame model.
module tb_uart_rx_oversample;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       sample_en;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int fails  = 0;
    int pulse_cnt = 0;
    int double_cnt = 0;
    logic prev_status = 1'b0;

    uart_rx_oversample #(.DATA_BITS(8), .OVS(16)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .sample_en (sample_en),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_status (rx_status),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (rx_status) pulse_cnt++;
        if (rx_status && prev_status) double_cnt++;
        prev_status = rx_status;
    end

    // One sample_en pulse after a random gap long enough for rx to cross the synchronizer.
    task automatic tick();
        int gap;
        gap = $urandom_range(2, 5);
        repeat (gap) @(negedge sysclk);
        sample_en = 1'b1;
        @(negedge sysclk);
        sample_en = 1'b0;
    endtask

    task automatic tick_val(input logic v);
        rx = v;
        tick();
    endtask

    // Line level at tick i of a frame: 16 ticks start, 8x16 data LSB first, 16 stop.
    function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int i);
        if (i < 16) return 1'b0;
        if (i < 144) return d[(i - 16) / 16];
        return stop;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop, input bit glitch);
        logic v;
        for (int i = 0; i < 160; i++) begin
            v = frame_bit(d, stop, i);
            if (glitch && i >= 16 && i < 144 && (i % 16) == 9) v = ~v;
            tick_val(v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx = 1'b1;
        sample_en = 1'b0;
        repeat (3) @(negedge sysclk);
        checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_status !== 1'b0) begin fails++; $display("FAIL reset_rx_status: got %b expected 0", rx_status); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b1;
        repeat (3) tick_val(1'b1);
        $display("test_reset done");
    endtask

    task automatic test_frame_0x55();
        int p0;
        p0 = pulse_cnt;
        for (int i = 0; i < 160; i++) begin
            tick_val(frame_bit(8'h55, 1'b1, i));
            if (i == 153) begin
                checks++; if (pulse_cnt !== p0) begin fails++; $display("FAIL early_status: got %0d pulses expected 0", pulse_cnt - p0); end
            end
            if (i == 154) begin
                checks++; if (rx_status !== 1'b1) begin fails++; $display("FAIL status_latency: got %b expected 1", rx_status); end
                @(negedge sysclk);
                checks++; if (rx_status !== 1'b0) begin fails++; $display("FAIL status_width: got %b expected 0", rx_status); end
            end
        end
        checks++; if (rx_data !== 8'h55) begin fails++; $display("FAIL data_55: got %h expected 55", rx_data); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL ferr_55: got %b expected 0", frame_err); end
        checks++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL pulses_55: got %0d expected 1", pulse_cnt - p0); end
        $display("frame 55: rx_data=%h frame_err=%b", rx_data, frame_err);
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulse_cnt;
        send_frame(8'hA3, 1'b1, 1'b0);
        checks++; if (rx_data !== 8'hA3) begin fails++; $display("FAIL b2b_first: got %h expected a3", rx_data); end
        send_frame(8'h0F, 1'b1, 1'b0);
        checks++; if (rx_data !== 8'h0F) begin fails++; $display("FAIL b2b_second: got %h expected 0f", rx_data); end
        checks++; if (pulse_cnt - p0 !== 2) begin fails++; $display("FAIL b2b_pulses: got %0d expected 2", pulse_cnt - p0); end
        $display("back-to-back: last rx_data=%h pulses=%0d", rx_data, pulse_cnt - p0);
    endtask

    task automatic test_glitch();
        int p0;
        logic [7:0] d0;
        p0 = pulse_cnt;
        d0 = rx_data;
        for (int i = 0; i < 3; i++) tick_val(1'b0);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
        for (int i = 3; i < 10; i++) tick_val(1'b1);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_before_vote: got %b expected 1", busy); end
        tick_val(1'b1);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_after_vote: got %b expected 0", busy); end
        checks++; if (pulse_cnt !== p0) begin fails++; $display("FAIL glitch_status: got %0d pulses expected 0", pulse_cnt - p0); end
        checks++; if (rx_data !== d0) begin fails++; $display("FAIL glitch_data_hold: got %h expected %h", rx_data, d0); end
        $display("glitch: busy=%b pulses=%0d", busy, pulse_cnt - p0);
    endtask

    task automatic test_frame_error();
        int p0;
        p0 = pulse_cnt;
        for (int i = 0; i < 144; i++) tick_val(frame_bit(8'hFF, 1'b0, i));
        for (int i = 0; i < 40; i++) tick_val(1'b0);
        checks++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
        checks++; if (rx_data !== 8'hFF) begin fails++; $display("FAIL ferr_data: got %h expected ff", rx_data); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL ferr_wait_high: got %b expected 1", busy); end
        checks++; if (pulse_cnt !== p0) begin fails++; $display("FAIL ferr_status: got %0d pulses expected 0", pulse_cnt - p0); end
        tick_val(1'b1);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL ferr_release: got %b expected 0", busy); end
        tick_val(1'b1);
        send_frame(8'h12, 1'b1, 1'b0);
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL ferr_clear: got %b expected 0", frame_err); end
        checks++; if (rx_data !== 8'h12) begin fails++; $display("FAIL ferr_next_data: got %h expected 12", rx_data); end
        $display("frame error: recovered rx_data=%h frame_err=%b", rx_data, frame_err);
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        p0 = pulse_cnt;
        for (int i = 0; i < 89; i++) tick_val(frame_bit(8'h5A, 1'b1, i));
        @(negedge sysclk);
        reset = 1'b0;
        sample_en = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge sysclk);
        sample_en = 1'b0;
        checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL midrst_data: got %h expected 00", rx_data); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL midrst_ferr: got %b expected 0", frame_err); end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick_val(1'b1);
        checks++; if (pulse_cnt !== p0) begin fails++; $display("FAIL midrst_status: got %0d pulses expected 0", pulse_cnt - p0); end
        send_frame(8'h3C, 1'b1, 1'b0);
        checks++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL midrst_next: got %h expected 3c", rx_data); end
        $display("reset mid-frame: next rx_data=%h", rx_data);
    endtask

    task automatic test_majority_glitch();
        int p0;
        p0 = pulse_cnt;
        send_frame(8'h96, 1'b1, 1'b1);
        checks++; if (rx_data !== 8'h96) begin fails++; $display("FAIL majority_data: got %h expected 96", rx_data); end
        checks++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL majority_pulses: got %0d expected 1", pulse_cnt - p0); end
        $display("majority vote: rx_data=%h", rx_data);
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       stop;
        int         gap;
        int         p0;
        for (int n = 0; n < 10; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            p0   = pulse_cnt;
            send_frame(d, stop, 1'b0);
            checks++; if (rx_data !== d) begin fails++; $display("FAIL rand_data[%0d]: got %h expected %h", n, rx_data, d); end
            checks++; if (frame_err !== !stop) begin fails++; $display("FAIL rand_ferr[%0d]: got %b expected %b", n, frame_err, !stop); end
            checks++; if (pulse_cnt - p0 !== (stop ? 1 : 0)) begin fails++; $display("FAIL rand_pulses[%0d]: got %0d expected %0d", n, pulse_cnt - p0, stop ? 1 : 0); end
            checks++; if (busy !== !stop) begin fails++; $display("FAIL rand_busy[%0d]: got %b expected %b", n, busy, !stop); end
            gap = stop ? $urandom_range(0, 6) : $urandom_range(1, 6);
            for (int g = 0; g < gap; g++) tick_val(1'b1);
            $display("random frame %0d: sent %h stop=%b got %h frame_err=%b", n, d, stop, rx_data, frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_frame_0x55();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_majority_glitch();
        test_random();
        checks++; if (double_cnt !== 0) begin fails++; $display("FAIL status_double: got %0d double pulses expected 0", double_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
